mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge.sv | 163 ++++++++++++++++
 tb/tb_mem_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding bridge from an MMU request/response strobe
// interface to an AXI4-Lite master port.
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to add a watchdog that
// aborts any transaction stalled for TIMEOUT_CYCLES cycles with bus_error=1.
module mem_bridge #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_enable,
  input  logic        req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        response_enable,
  output logic [31:0] resp_data,
  output logic        bus_error,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  // State | meaning
  // IDLE    | no transaction; request_enable sampled here only
  // RD_ADDR | m_arvalid held until m_arready
  // RD_DATA | m_rready held until m_rvalid
  // WR_REQ  | AW and W offered; each drops on its own ready
  // WR_RESP | m_bready held until m_bvalid
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t state;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  // Write phase is complete once each channel is either already accepted or
  // being accepted this cycle.
  logic aw_ok, w_ok;
  assign aw_ok = !m_awvalid || m_awready;
  assign w_ok  = !m_wvalid  || m_wready;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wd_cnt;
  logic          hs;
  // Any handshake counts as progress and restarts the watchdog.
  assign hs = (m_arvalid && m_arready) || (m_rvalid && m_rready) ||
              (m_awvalid && m_awready) || (m_wvalid && m_wready) ||
              (m_bvalid && m_bready);
`endif

  // Transaction FSM with registered AXI and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      response_enable <= 1'b0;
      resp_data       <= '0;
      bus_error       <= 1'b0;
      m_araddr        <= '0;
      m_arvalid       <= 1'b0;
      m_rready        <= 1'b0;
      m_awaddr        <= '0;
      m_awvalid       <= 1'b0;
      m_wdata         <= '0;
      m_wstrb         <= '0;
      m_wvalid        <= 1'b0;
      m_bready        <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      wd_cnt          <= '0;
`endif
    end else begin
      response_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (request_enable) begin
            if (req_mode) begin
              m_awaddr  <= req_addr;
              m_wdata   <= req_wdata;
              m_wstrb   <= req_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              m_araddr  <= req_addr;
              m_arvalid <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            m_rready        <= 1'b0;
            response_enable <= 1'b1;
            resp_data       <= m_rdata;
            bus_error       <= (m_rresp != 2'b00);
            state           <= IDLE;
          end
        end
        WR_REQ: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            m_bready        <= 1'b0;
            response_enable <= 1'b1;
            resp_data       <= '0;
            bus_error       <= (m_bresp != 2'b00);
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef MEM_BRIDGE_TIMEOUT_EN
      // Watchdog overrides the FSM: abandon the transaction, report an error.
      if (state == IDLE || hs) begin
        wd_cnt <= '0;
      end else if (wd_cnt == LIMIT) begin
        wd_cnt          <= '0;
        m_arvalid       <= 1'b0;
        m_rready        <= 1'b0;
        m_awvalid       <= 1'b0;
        m_wvalid        <= 1'b0;
        m_bready        <= 1'b0;
        response_enable <= 1'b1;
        bus_error       <= 1'b1;
        resp_data       <= '0;
        state           <= IDLE;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge.
module tb_mem_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1023;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        request_enable = 1'b0;
  logic        req_mode = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        bus_error;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0;
  logic        m_bready;

  int tests = 0;
  int fails = 0;

  mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data), .bus_error(bus_error),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a single-cycle request strobe for the current cycle.
  task automatic request(input logic mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    request_enable = 1'b1;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_resp_en", {31'd0, response_enable}, 32'd0);
    check("rst_valids", {27'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    rst = 1'b0;
    step();

    // Zero-wait read: request cycle 0, response cycle 3
    m_arready = 1'b1;
    request(1'b0, 32'h8000_1000, 32'h0, 4'h0);
    step();
    request_enable = 1'b0;
    check("rd_arvalid", {31'd0, m_arvalid}, 32'd1);
    check("rd_araddr", m_araddr, 32'h8000_1000);
    step();
    check("rd_arvalid_drop", {31'd0, m_arvalid}, 32'd0);
    check("rd_rready", {31'd0, m_rready}, 32'd1);
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
    step();
    m_rvalid = 1'b0; m_arready = 1'b0;
    check("rd_resp_en_c3", {31'd0, response_enable}, 32'd1);
    check("rd_resp_data", resp_data, 32'hDEAD_BEEF);
    check("rd_bus_error", {31'd0, bus_error}, 32'd0);
    check("rd_rready_drop", {31'd0, m_rready}, 32'd0);
    step();
    check("rd_pulse_single", {31'd0, response_enable}, 32'd0);
    check("rd_data_hold", resp_data, 32'hDEAD_BEEF);

    // Write with wready two cycles after awready
    request(1'b1, 32'h8000_2000, 32'h1234_5678, 4'h3);
    step();
    request_enable = 1'b0;
    check("wr_valids", {30'd0, m_awvalid, m_wvalid}, 32'd3);
    check("wr_awaddr", m_awaddr, 32'h8000_2000);
    check("wr_wdata", m_wdata, 32'h1234_5678);
    check("wr_wstrb", {28'd0, m_wstrb}, 32'h3);
    m_awready = 1'b1;
    step();
    m_awready = 1'b0;
    check("wr_aw_drop_only", {30'd0, m_awvalid, m_wvalid}, 32'd1);
    step();
    check("wr_w_held", {30'd0, m_awvalid, m_wvalid}, 32'd1);
    check("wr_no_bready_yet", {31'd0, m_bready}, 32'd0);
    m_wready = 1'b1;
    step();
    m_wready = 1'b0;
    check("wr_w_drop", {30'd0, m_awvalid, m_wvalid}, 32'd0);
    check("wr_bready", {31'd0, m_bready}, 32'd1);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    step();
    m_bvalid = 1'b0;
    check("wr_resp_en", {31'd0, response_enable}, 32'd1);
    check("wr_resp_data", resp_data, 32'd0);
    check("wr_bus_error", {31'd0, bus_error}, 32'd0);
    step();
    check("wr_pulse_single", {31'd0, response_enable}, 32'd0);

    // Read with SLVERR response
    m_arready = 1'b1;
    request(1'b0, 32'h8000_0040, 32'h0, 4'h0);
    step();
    request_enable = 1'b0;
    step();
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b10;
    step();
    m_rvalid = 1'b0; m_rresp = 2'b00;
    check("err_resp_en", {31'd0, response_enable}, 32'd1);
    check("err_bus_error", {31'd0, bus_error}, 32'd1);
    check("err_resp_data", resp_data, 32'hCAFE_F00D);
    step();

    // Request in RD_DATA dropped, request in response cycle accepted
    request(1'b0, 32'h8000_0100, 32'h0, 4'h0);
    step();
    request_enable = 1'b0;
    step();
    m_arready = 1'b0;
    request(1'b1, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF);
    step();
    request_enable = 1'b0;
    check("drop_no_awvalid", {31'd0, m_awvalid}, 32'd0);
    check("drop_still_rdata", {31'd0, m_rready}, 32'd1);
    m_rvalid = 1'b1; m_rdata = 32'h1111_1111;
    step();
    m_rvalid = 1'b0;
    check("b2b_resp_en", {31'd0, response_enable}, 32'd1);
    check("b2b_resp_data", resp_data, 32'h1111_1111);
    request(1'b0, 32'h8000_3000, 32'h0, 4'h0);
    step();
    request_enable = 1'b0;
    check("b2b_accepted", {31'd0, m_arvalid}, 32'd1);
    check("b2b_araddr", m_araddr, 32'h8000_3000);
    step();
    step();
    check("b2b_arvalid_held", {31'd0, m_arvalid}, 32'd1);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h2222_2222;
    step();
    m_rvalid = 1'b0;
    check("b2b_second_resp", {31'd0, response_enable}, 32'd1);
    check("b2b_second_data", resp_data, 32'h2222_2222);
    check("b2b_second_err", {31'd0, bus_error}, 32'd0);
    step();

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // Stalled read address: watchdog abort after 16 stalled cycles
    request(1'b0, 32'h8000_4000, 32'h0, 4'h0);
    step();
    request_enable = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("to_no_early_pulse", {31'd0, response_enable}, 32'd0);
    check("to_arvalid_held", {31'd0, m_arvalid}, 32'd1);
    step();
    check("to_resp_en", {31'd0, response_enable}, 32'd1);
    check("to_bus_error", {31'd0, bus_error}, 32'd1);
    check("to_resp_data", resp_data, 32'd0);
    check("to_arvalid_drop", {31'd0, m_arvalid}, 32'd0);
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h3333_3333;
    step();
    step();
    m_arready = 1'b0; m_rvalid = 1'b0;
    check("to_late_beat_ignored", {31'd0, response_enable}, 32'd0);
    check("to_late_no_rready", {31'd0, m_rready}, 32'd0);
`endif

    // Reset while waiting in WR_RESP
    m_awready = 1'b1; m_wready = 1'b1;
    request(1'b1, 32'h8000_5000, 32'hA5A5_A5A5, 4'hF);
    step();
    request_enable = 1'b0;
    step();
    m_awready = 1'b0; m_wready = 1'b0;
    check("rw_in_wr_resp", {31'd0, m_bready}, 32'd1);
    rst = 1'b1; m_bvalid = 1'b1;
    step();
    check("rw_valids_zero", {27'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 32'd0);
    check("rw_resp_zero", {30'd0, response_enable, bus_error}, 32'd0);
    check("rw_data_zero", resp_data | m_awaddr | m_wdata | m_araddr | {28'd0, m_wstrb}, 32'd0);
    rst = 1'b0;
    step();
    m_bvalid = 1'b0;
    check("rw_no_pulse_after", {31'd0, response_enable}, 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
